// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding and load-use hazard detection for the execute stage.
//   Each source operand is resolved against the in-flight pipeline stages
//   (youngest first), then against a small history of write-back results
//   captured while stalled, then falls back to regfile read data.
//
// Ports
//   clk, rst_n           clock / asynchronous active-low reset
//   hold                 freezes history, stall counter and watchdog
//   flush                invalidates history, clears counters, masks stall
//   src_valid            execute slot holds a real instruction
//   src_idx, reg_data    per-source register index and regfile data
//   stg_valid/is_load    per-stage instruction qualifiers
//   stg_tgt, stg_data    per-stage, per-port destination index and result
//   op, fwd_sel          resolved operands and where they came from
//   stall                load-use stall request
//   stall_cnt            consecutive stall cycles (saturating)
//   stall_timeout        sticky watchdog flag
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int NSRC       = 2,
  parameter int NSTAGE     = 4,
  parameter int NDST       = 2,
  parameter int HIST       = 2,
  parameter int LOAD_READY = 3,
  parameter int CNTW       = 8,
  parameter int TIMEOUT    = 64,
  parameter int SELW       = $clog2(NSTAGE + HIST + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        src_valid,
  input  logic [NSRC*5-1:0]           src_idx,
  input  logic [NSRC*XLEN-1:0]        reg_data,
  input  logic [NSTAGE-1:0]           stg_valid,
  input  logic [NSTAGE-1:0]           stg_is_load,
  input  logic [NSTAGE*NDST*5-1:0]    stg_tgt,
  input  logic [NSTAGE*NDST*XLEN-1:0] stg_data,
  output logic [NSRC*XLEN-1:0]        op,
  output logic [NSRC*SELW-1:0]        fwd_sel,
  output logic                        stall,
  output logic [CNTW-1:0]             stall_cnt,
  output logic                        stall_timeout
);

  localparam logic [CNTW:0] TIMEOUT_V = (CNTW+1)'(TIMEOUT);

  // A history tgt of 0 marks the entry invalid: index 0 never hits.
  logic [HIST-1:0][NDST-1:0][4:0]      hist_tgt_q, hist_tgt_d;
  logic [HIST-1:0][NDST-1:0][XLEN-1:0] hist_data_q, hist_data_d;
  logic [CNTW-1:0]                     stall_cnt_q, stall_cnt_d;
  logic                                stall_timeout_q, stall_timeout_d;
  logic                                raw_hazard;
  logic [CNTW:0]                       cnt_inc;

  // Operand resolution and load-use detection.
  always_comb begin
    logic       hit;
    logic [4:0] idx;
    op         = '0;
    fwd_sel    = '0;
    raw_hazard = 1'b0;
    hit        = 1'b0;
    idx        = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx = src_idx[5*i +: 5];
      hit = 1'b0;
      op[i*XLEN +: XLEN]      = reg_data[i*XLEN +: XLEN];
      fwd_sel[i*SELW +: SELW] = SELW'(NSTAGE + HIST);
      if (idx != 5'd0) begin
        // Bubbles carry tgt 0, so stg_valid need not qualify a hit.
        for (int s = 0; s < NSTAGE; s++) begin
          for (int j = 0; j < NDST; j++) begin
            if (!hit && stg_tgt[(s*NDST+j)*5 +: 5] == idx) begin
              hit = 1'b1;
              op[i*XLEN +: XLEN]      = stg_data[(s*NDST+j)*XLEN +: XLEN];
              fwd_sel[i*SELW +: SELW] = SELW'(s);
            end
          end
        end
        for (int h = 0; h < HIST; h++) begin
          for (int j = 0; j < NDST; j++) begin
            if (!hit && hist_tgt_q[h][j] == idx) begin
              hit = 1'b1;
              op[i*XLEN +: XLEN]      = hist_data_q[h][j];
              fwd_sel[i*SELW +: SELW] = SELW'(NSTAGE + h);
            end
          end
        end
      end
      // Every source index is matched, whether or not the opcode reads it.
      for (int s = 0; s < NSTAGE; s++) begin
        for (int j = 0; j < NDST; j++) begin
          if (s < LOAD_READY && stg_valid[s] && stg_is_load[s] &&
              stg_tgt[(s*NDST+j)*5 +: 5] != 5'd0 &&
              stg_tgt[(s*NDST+j)*5 +: 5] == idx)
            raw_hazard = 1'b1;
        end
      end
    end
  end

  assign stall   = raw_hazard && src_valid && !flush;
  assign cnt_inc = {1'b0, stall_cnt_q} + {{CNTW{1'b0}}, 1'b1};

  // History, stall counter and watchdog next-state.
  always_comb begin
    hist_tgt_d      = hist_tgt_q;
    hist_data_d     = hist_data_q;
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    if (!hold) begin
      if (flush) begin
        hist_tgt_d      = '0;
        stall_cnt_d     = '0;
        stall_timeout_d = 1'b0;
      end else if (stall) begin
        for (int h = 1; h < HIST; h++) begin
          hist_tgt_d[h]  = hist_tgt_q[h-1];
          hist_data_d[h] = hist_data_q[h-1];
        end
        hist_tgt_d[0]  = stg_tgt[(NSTAGE-1)*NDST*5 +: NDST*5];
        hist_data_d[0] = stg_data[(NSTAGE-1)*NDST*XLEN +: NDST*XLEN];
        if (stall_cnt_q != '1)
          stall_cnt_d = cnt_inc[CNTW-1:0];
        if (cnt_inc == TIMEOUT_V)
          stall_timeout_d = 1'b1;
      end else begin
        // Stall released: captured results are now in the regfile, so drop
        // them before they can shadow a newer regfile value.
        hist_tgt_d  = '0;
        stall_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_tgt_q      <= '0;
      hist_data_q     <= '0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      hist_tgt_q      <= hist_tgt_d;
      hist_data_q     <= hist_data_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int XLEN = 32, NSRC = 2, NSTAGE = 4, NDST = 2, HIST = 2;
  localparam int LOAD_READY = 3, CNTW = 3, TIMEOUT = 4;
  localparam int SELW = $clog2(NSTAGE + HIST + 1);
  localparam logic [31:0] REG0 = 32'hAAAA_0000, REG1 = 32'hBBBB_0001;

  logic clk = 1'b0;
  logic rst_n, hold, flush, src_valid;
  logic [NSRC*5-1:0]           src_idx;
  logic [NSRC*XLEN-1:0]        reg_data;
  logic [NSTAGE-1:0]           stg_valid, stg_is_load;
  logic [NSTAGE*NDST*5-1:0]    stg_tgt;
  logic [NSTAGE*NDST*XLEN-1:0] stg_data;
  logic [NSRC*XLEN-1:0]        op;
  logic [NSRC*SELW-1:0]        fwd_sel;
  logic                        stall, stall_timeout;
  logic [CNTW-1:0]             stall_cnt;

  fwd_hazard_unit #(.XLEN(XLEN), .NSRC(NSRC), .NSTAGE(NSTAGE), .NDST(NDST),
                    .HIST(HIST), .LOAD_READY(LOAD_READY), .CNTW(CNTW),
                    .TIMEOUT(TIMEOUT), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .src_valid(src_valid),
    .src_idx(src_idx), .reg_data(reg_data), .stg_valid(stg_valid),
    .stg_is_load(stg_is_load), .stg_tgt(stg_tgt), .stg_data(stg_data),
    .op(op), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout));

  always #5 clk = ~clk;

  // Scoreboard: expectation and observed value queued together at each
  // sample point, compared by each test at its end.
  string       name_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int total = 0, bad = 0;

  localparam int K_OP0 = 0, K_OP1 = 1, K_SEL0 = 2, K_SEL1 = 3;
  localparam int K_STALL = 4, K_CNT = 5, K_TMO = 6;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_OP0:   return op[31:0];
      K_OP1:   return op[63:32];
      K_SEL0:  return 32'(fwd_sel[SELW-1:0]);
      K_SEL1:  return 32'(fwd_sel[2*SELW-1:SELW]);
      K_STALL: return {31'b0, stall};
      K_CNT:   return 32'(stall_cnt);
      K_TMO:   return {31'b0, stall_timeout};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic note(string name, int kind, logic [31:0] v);
    name_q.push_back(name);
    exp_q.push_back(v);
    act_q.push_back(observe(kind));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    rst_n = 1'b1; hold = 1'b0; flush = 1'b0; src_valid = 1'b0;
    src_idx = '0; reg_data = {REG1, REG0};
    stg_valid = '0; stg_is_load = '0; stg_tgt = '0; stg_data = '0;
  endtask

  task automatic set_slot(int s, int j, logic [4:0] tgt, logic [31:0] data);
    stg_tgt[(s*NDST+j)*5 +: 5]        = tgt;
    stg_data[(s*NDST+j)*XLEN +: XLEN] = data;
  endtask

  // Stage-0 load of r20 with source 1 reading r20: a stall source that
  // never collides with the registers under test.
  task automatic make_stall();
    stg_valid[0] = 1'b1; stg_is_load[0] = 1'b1;
    set_slot(0, 0, 5'd20, 32'h2020_2020);
    src_idx[9:5] = 5'd20; src_valid = 1'b1;
  endtask

  task automatic test_reset();
    string n; logic [31:0] e, a;
    clear_inputs();
    rst_n = 1'b0;
    src_idx[4:0] = 5'd3;
    #1;
    note("rst_op0", K_OP0, REG0);
    note("rst_sel0", K_SEL0, 32'd6);
    note("rst_stall", K_STALL, 32'd0);
    note("rst_cnt", K_CNT, 32'd0);
    note("rst_tmo", K_TMO, 32'd0);
    set_slot(1, 1, 5'd3, 32'h1313_1313);
    #1;
    note("rst_stage_hit_op0", K_OP0, 32'h1313_1313);
    note("rst_stage_hit_sel0", K_SEL0, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_priority();
    string n; logic [31:0] e, a;
    tick();
    clear_inputs();
    stg_valid[1] = 1'b1; stg_is_load[1] = 1'b1;
    set_slot(1, 0, 5'd20, 32'h2020_2020);
    src_idx[9:5] = 5'd20; src_valid = 1'b1;
    set_slot(3, 0, 5'd5, 32'h5555_5555);
    #1;
    note("pri_stall", K_STALL, 32'd1);
    tick();
    set_slot(3, 0, 5'd0, 32'h0);
    set_slot(0, 1, 5'd5, 32'h0101_0101);
    set_slot(2, 0, 5'd5, 32'h2222_2222);
    src_idx[4:0] = 5'd5;
    #1;
    note("pri_s0_op0", K_OP0, 32'h0101_0101);
    note("pri_s0_sel0", K_SEL0, 32'd0);
    set_slot(0, 1, 5'd0, 32'h0);
    #1;
    note("pri_s2_op0", K_OP0, 32'h2222_2222);
    note("pri_s2_sel0", K_SEL0, 32'd2);
    set_slot(2, 0, 5'd0, 32'h0);
    #1;
    note("pri_h0_op0", K_OP0, 32'h5555_5555);
    note("pri_h0_sel0", K_SEL0, 32'd4);
    note("pri_cnt", K_CNT, 32'd1);
    src_valid = 1'b0;
    tick();
    #1;
    note("pri_rel_op0", K_OP0, REG0);
    note("pri_rel_sel0", K_SEL0, 32'd6);
    note("pri_rel_cnt", K_CNT, 32'd0);
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_load_use();
    string n; logic [31:0] e, a;
    tick();
    clear_inputs();
    stg_valid[1] = 1'b1; stg_is_load[1] = 1'b1;
    set_slot(1, 0, 5'd7, 32'h0000_0077);
    src_idx[9:5] = 5'd7; src_valid = 1'b1;
    #1;
    note("lu_stall", K_STALL, 32'd1);
    note("lu_op1", K_OP1, 32'h0000_0077);
    note("lu_sel1", K_SEL1, 32'd1);
    src_valid = 1'b0;
    #1;
    note("lu_bubble_stall", K_STALL, 32'd0);
    src_valid = 1'b1; flush = 1'b1;
    #1;
    note("lu_flush_stall", K_STALL, 32'd0);
    flush = 1'b0;
    tick();
    stg_valid = '0; stg_is_load = '0; set_slot(1, 0, 5'd0, 32'h0);
    stg_valid[3] = 1'b1; stg_is_load[3] = 1'b1;
    set_slot(3, 0, 5'd7, 32'h3737_3737);
    #1;
    note("lu_s3_stall", K_STALL, 32'd0);
    note("lu_s3_op1", K_OP1, 32'h3737_3737);
    note("lu_s3_sel1", K_SEL1, 32'd3);
    stg_valid = '0; stg_is_load = '0; set_slot(3, 0, 5'd0, 32'h0);
    stg_valid[2] = 1'b1; stg_is_load[2] = 1'b1;
    set_slot(2, 1, 5'd7, 32'h2727_2727);
    #1;
    note("lu_s2_stall", K_STALL, 32'd1);
    note("lu_s2_op1", K_OP1, 32'h2727_2727);
    stg_is_load[2] = 1'b0;
    #1;
    note("lu_notload_stall", K_STALL, 32'd0);
    stg_is_load[2] = 1'b1; stg_valid[2] = 1'b0;
    #1;
    note("lu_invalid_stall", K_STALL, 32'd0);
    stg_tgt = '0; stg_data = '0;
    set_slot(0, 0, 5'd0, 32'hDEAD_BEEF);
    src_idx[9:5] = 5'd0;
    #1;
    note("lu_r0_op1", K_OP1, REG1);
    note("lu_r0_sel1", K_SEL1, 32'd6);
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_history();
    string n; logic [31:0] e, a;
    tick();
    clear_inputs();
    make_stall();
    set_slot(3, 0, 5'd9, 32'hA);
    tick();
    set_slot(3, 0, 5'd10, 32'hB);
    tick();
    set_slot(3, 0, 5'd11, 32'hC);
    tick();
    set_slot(3, 0, 5'd0, 32'h0);
    src_idx[4:0] = 5'd11; src_idx[9:5] = 5'd10;
    #1;
    note("hist_rel_stall", K_STALL, 32'd0);
    note("hist_h0_op0", K_OP0, 32'hC);
    note("hist_h0_sel0", K_SEL0, 32'd4);
    note("hist_h1_op1", K_OP1, 32'hB);
    note("hist_h1_sel1", K_SEL1, 32'd5);
    note("hist_cnt3", K_CNT, 32'd3);
    note("hist_tmo", K_TMO, 32'd0);
    tick();
    #1;
    note("hist_inv_op1", K_OP1, REG1);
    note("hist_inv_sel1", K_SEL1, 32'd6);
    note("hist_inv_sel0", K_SEL0, 32'd6);
    note("hist_inv_cnt", K_CNT, 32'd0);
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_watchdog();
    string n; logic [31:0] e, a;
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    make_stall();
    for (int k = 1; k <= 10; k++) begin
      tick();
      note($sformatf("wd_cnt_%0d", k), K_CNT, (k > 7) ? 32'd7 : 32'(k));
      note($sformatf("wd_tmo_%0d", k), K_TMO, (k >= TIMEOUT) ? 32'd1 : 32'd0);
    end
    src_valid = 1'b0;
    tick();
    note("wd_drop_cnt", K_CNT, 32'd0);
    note("wd_drop_tmo", K_TMO, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    note("wd_flush_tmo", K_TMO, 32'd0);
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_hold();
    string n; logic [31:0] e, a;
    tick();
    clear_inputs();
    make_stall();
    set_slot(3, 0, 5'd12, 32'h0000_012C);
    tick();
    note("hold_pre_cnt", K_CNT, 32'd1);
    hold = 1'b1;
    set_slot(3, 0, 5'd13, 32'h0000_013D);
    repeat (5) tick();
    set_slot(3, 0, 5'd0, 32'h0);
    src_idx[4:0] = 5'd12;
    #1;
    note("hold_cnt", K_CNT, 32'd1);
    note("hold_h0_sel0", K_SEL0, 32'd4);
    note("hold_h0_op0", K_OP0, 32'h0000_012C);
    note("hold_stall", K_STALL, 32'd1);
    flush = 1'b1;
    #1;
    note("holdflush_stall", K_STALL, 32'd0);
    tick();
    note("holdflush_cnt", K_CNT, 32'd1);
    note("holdflush_sel0", K_SEL0, 32'd4);
    flush = 1'b0; hold = 1'b0;
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  task automatic test_async_reset();
    string n; logic [31:0] e, a;
    // Continues the stall left by test_hold (stall_cnt == 1).
    set_slot(3, 0, 5'd14, 32'h0000_014E);
    repeat (4) tick();
    set_slot(3, 0, 5'd0, 32'h0);
    src_idx[4:0] = 5'd14;
    #1;
    note("ar_pre_tmo", K_TMO, 32'd1);
    note("ar_pre_cnt", K_CNT, 32'd5);
    note("ar_pre_sel0", K_SEL0, 32'd4);
    rst_n = 1'b0;
    #1;
    note("ar_cnt", K_CNT, 32'd0);
    note("ar_tmo", K_TMO, 32'd0);
    note("ar_sel0", K_SEL0, 32'd6);
    note("ar_op0", K_OP0, REG0);
    clear_inputs();
    tick();
    while (exp_q.size() > 0) begin
      n = name_q.pop_front(); e = exp_q.pop_front(); a = act_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL %s: got %0h expected %0h", n, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_history();
    test_watchdog();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
